// File: rtl/muldiv_seq.sv
// Iterative multi-cycle multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Define MULDIV_SIGNED_EN to honour op[1] as the signed-operation select.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result2,
  output logic             div_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result2_q, result2_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] x_mag, y_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

`ifdef MULDIV_SIGNED_EN
  logic is_div_q, is_div_d;
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  assign x_mag = (op[1] && x[WIDTH-1]) ? -x : x;
  assign y_mag = (op[1] && y[WIDTH-1]) ? -y : y;
`else
  logic unused_op1;

  assign unused_op1 = op[1];
  assign x_mag      = x;
  assign y_mag      = y;
`endif

  // MUL: conditional add into the high half; the carry shifts back in with {carry, hi, lo} >> 1.
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  // DIV: bit WIDTH of the 33-bit difference is the borrow, i.e. the trial went negative.
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    result_d   = result_q;
    result2_d  = result2_q;
    div_zero_d = div_zero_q;
`ifdef MULDIV_SIGNED_EN
    is_div_d   = is_div_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d      = '0;
          hi_d       = '0;
          div_zero_d = 1'b0;
`ifdef MULDIV_SIGNED_EN
          is_div_d   = op[0];
          neg_quo_d  = op[1] & (x[WIDTH-1] ^ y[WIDTH-1]);
          neg_rem_d  = op[1] & x[WIDTH-1];
`endif
          if (!op[0]) begin
            lo_d    = y_mag;
            opnd_d  = x_mag;
            state_d = S_MUL;
          end else if (y == '0) begin
            result_d   = '1;
            result2_d  = x;
            div_zero_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            lo_d    = x_mag;
            opnd_d  = y_mag;
            state_d = S_DIV;
          end
        end
      end

      S_MUL: begin
        hi_d  = mul_sum[WIDTH:1];
        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(WIDTH - 1)) state_d = S_FIX;
      end

      S_DIV: begin
        hi_d  = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(WIDTH - 1)) state_d = S_FIX;
      end

      S_FIX: begin
`ifdef MULDIV_SIGNED_EN
        if (!is_div_q) begin
          {result2_d, result_d} = neg_quo_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        end else begin
          result_d  = neg_quo_q ? -lo_q : lo_q;
          result2_d = neg_rem_q ? -hi_q : hi_q;
        end
`else
        result_d  = lo_q;
        result2_d = hi_q;
`endif
        state_d = S_DONE;
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      result_q   <= '0;
      result2_q  <= '0;
      div_zero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      is_div_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values of the others.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      result_q   <= result_d;
      result2_q  <= result2_d;
      div_zero_q <= div_zero_d;
`ifdef MULDIV_SIGNED_EN
      is_div_q   <= is_div_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign result2  = result2_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus randomized operations
// checked against an arithmetic reference model (signed cases when MULDIV_SIGNED_EN is defined).
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] result2;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .x        (x),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .result2  (result2),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result as {div_zero, result2, result}, straight from integer arithmetic.
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] o);
    logic               sgn;
    logic        [63:0] ua, ub, up;
    logic signed [63:0] sa, sb, sp, sq, sr;
    sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sgn = o[1];
`endif
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = $signed(a);
    sb = $signed(b);
    if (!o[0]) begin
      if (sgn) begin
        sp = sa * sb;
        return {1'b0, sp};
      end
      up = ua * ub;
      return {1'b0, up};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (sgn) begin
      sq = sa / sb;
      sr = sa % sb;
      return {1'b0, sr[31:0], sq[31:0]};
    end
    up = ua / ub;
    ua = ua % ub;
    return {1'b0, ua[31:0], up[31:0]};
  endfunction

  // Called at a negedge while the DUT is idle; returns at the negedge of the idle cycle after done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                        input string tag, input bit intrude);
    logic [64:0] exp;
    int          lat_exp;
    int          n;
    bit          got;
    bit          busy_bad;
    exp     = model(a, b, o);
    lat_exp = (o[0] && b == 32'd0) ? 1 : 34;
    start   = 1'b1;
    x       = a;
    y       = b;
    op      = o;
    @(posedge clk);
    #1;
    start    = 1'b0;
    x        = $urandom;
    y        = $urandom;
    op       = 2'($urandom_range(0, 3));
    n        = 0;
    got      = 1'b0;
    busy_bad = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (n == 1 && !done) check({tag, "/dz_clear"}, 64'(div_zero), 64'(0));
      if (done === 1'b1) got = 1'b1;
      if (intrude && n == 5) begin
        start = 1'b1;
        x     = $urandom;
        y     = $urandom;
        op    = 2'($urandom_range(0, 3));
      end
      if (intrude && n == 6) start = 1'b0;
    end
    check({tag, "/latency"}, 64'(n), 64'(lat_exp));
    check({tag, "/busy"}, 64'(busy_bad), 64'(0));
    check({tag, "/result"}, 64'(result), 64'(exp[31:0]));
    check({tag, "/result2"}, 64'(result2), 64'(exp[63:32]));
    check({tag, "/div_zero"}, 64'(div_zero), 64'(exp[64]));
    @(negedge clk);
    check({tag, "/idle"}, {62'b0, busy, done}, 64'(0));
    check({tag, "/hold"}, {div_zero, 31'b0, result}, {exp[64], 31'b0, exp[31:0]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    x     = '0;
    y     = '0;
    repeat (2) @(negedge clk);
    check("reset/flags", {61'b0, busy, done, div_zero}, 64'(0));
    check("reset/results", {result2, result}, 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, "mul_max", 1'b0);
    check("mul_max/const", {result2, result}, 64'hFFFF_FFFE_0000_0001);
    run_op(32'd100, 32'd7, 2'b01, "div_100_7", 1'b0);
    check("div_100_7/const", {result2, result}, {32'd2, 32'd14});
    run_op(32'h1234_5678, 32'd0, 2'b01, "div_zero", 1'b0);
    check("div_zero/const", {result2, result}, 64'h1234_5678_FFFF_FFFF);
    run_op(32'h0000_0000, 32'hDEAD_BEEF, 2'b00, "mul_zero", 1'b0);
    run_op(32'h0000_0000, 32'h0000_0003, 2'b01, "div_of_zero", 1'b0);
    run_op(32'h0001_2345, 32'h0000_6789, 2'b00, "busy_guard", 1'b1);

    // Abort a multiply part-way through with an asynchronous reset.
    start = 1'b1;
    x     = 32'h0BAD_F00D;
    y     = 32'h1357_9BDF;
    op    = 2'b00;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_reset/flags", {61'b0, busy, done, div_zero}, 64'(0));
    check("mid_reset/results", {result2, result}, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h0BAD_F00D, 32'h1357_9BDF, 2'b00, "after_reset", 1'b0);

    for (int i = 0; i < 12; i++) begin
      logic [31:0] ra, rb;
      logic [1:0]  ro;
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      ro = 2'($urandom_range(0, 3));
      run_op(ra, rb, ro, $sformatf("rand%0d", i), 1'b0);
    end

`ifdef MULDIV_SIGNED_EN
    run_op(-32'sd7, 32'sd2, 2'b11, "s_div_m7_2", 1'b0);
    check("s_div_m7_2/const", {result2, result}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(-32'sd3, 32'sd5, 2'b10, "s_mul_m3_5", 1'b0);
    check("s_mul_m3_5/const", {result2, result}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b11, "s_div_ovf", 1'b0);
    check("s_div_ovf/const", {result2, result}, {32'h0, 32'h8000_0000});
    run_op(32'hFFFF_FFF0, 32'd0, 2'b11, "s_div_zero", 1'b0);
    check("s_div_zero/const", {result2, result}, 64'hFFFF_FFF0_FFFF_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
